// File: rtl/time_entry_pkg.sv
// Shared types and constants for the microwave time-entry register.
// Used by key_debouncer and time_entry_register.
package time_entry_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned MAX_SEC_TENS = 5;
    localparam int unsigned NUM_KEYS     = 10;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2
    } key_state_e;

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] k);
        return (k != '0) && ((k & (k - 1'b1)) == '0);
    endfunction

    function automatic logic [DIGIT_W-1:0] key_to_digit(input logic [NUM_KEYS-1:0] k);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (k[i]) begin
                d = DIGIT_W'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Qualifies a single one-hot key press: DEBOUNCE_CYCLES stable samples give one
// accept pulse, then the key must be released before another press counts.
module key_debouncer
    import time_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                entry_en,
    output logic                accept,
    output logic [DIGIT_W-1:0]  key_digit
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES);

    key_state_e          state_q, state_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic [3:0]          count_q, count_d;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        count_d = count_q;
        accept  = 1'b0;
        if (!entry_en) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_onehot(keypad)) begin
                        key_d   = keypad;
                        count_d = 4'd1;
                        // A one-cycle debounce accepts on the very first sample.
                        if (count_d == CNT_MAX) begin
                            accept  = 1'b1;
                            state_d = WAIT_RELEASE;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (keypad == key_q) begin
                        count_d = count_q + 4'd1;
                        if (count_d == CNT_MAX) begin
                            accept  = 1'b1;
                            state_d = WAIT_RELEASE;
                        end
                    end else begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (keypad == '0) begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign key_digit = key_to_digit(key_d);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            key_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/time_entry_register.sv
// Three-digit BCD time-entry shift register with commit strobe to the cook counters.
// Optional key-accept beep pulse is built only when KEYPAD_BEEP_EN is defined.
module time_entry_register
    import time_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned BEEP_CYCLES     = 8
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                entry_en,
    input  logic                start,
    output logic [DIGIT_W-1:0]  sec_ones,
    output logic [DIGIT_W-1:0]  sec_tens,
    output logic [DIGIT_W-1:0]  minutes,
    output logic                loadn,
`ifdef KEYPAD_BEEP_EN
    output logic                beep,
`endif
    output logic                entry_error
);

    logic               accept;
    logic [DIGIT_W-1:0] key_digit;

    logic [DIGIT_W-1:0] sec_ones_q, sec_ones_d;
    logic [DIGIT_W-1:0] sec_tens_q, sec_tens_d;
    logic [DIGIT_W-1:0] minutes_q, minutes_d;
    logic               loadn_q, loadn_d;
    logic               commit;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock    (clock),
        .clear    (clear),
        .keypad   (keypad),
        .entry_en (entry_en),
        .accept   (accept),
        .key_digit(key_digit)
    );

    assign entry_error = (sec_tens_q > DIGIT_W'(MAX_SEC_TENS));

    // Start is ignored during the strobe cycle so one commit yields exactly one pulse.
    assign commit = start && !entry_error && loadn_q &&
                    ((sec_ones_q | sec_tens_q | minutes_q) != '0);

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        minutes_d  = minutes_q;
        loadn_d    = 1'b1;
        if (!loadn_q) begin
            sec_ones_d = '0;
            sec_tens_d = '0;
            minutes_d  = '0;
        end else if (commit) begin
            loadn_d = 1'b0;
        end else if (accept) begin
            minutes_d  = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = key_digit;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            minutes_q  <= '0;
            loadn_q    <= 1'b1;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            minutes_q  <= minutes_d;
            loadn_q    <= loadn_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign minutes  = minutes_q;
    assign loadn    = loadn_q;

`ifdef KEYPAD_BEEP_EN
    localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);

    logic              accept_q, accept_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

    always_comb begin
        accept_d   = accept;
        beep_cnt_d = beep_cnt_q;
        if (accept_q) begin
            beep_cnt_d = BEEP_W'(BEEP_CYCLES);
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            accept_q   <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            accept_q   <= accept_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep = (beep_cnt_q != '0);
`else
    logic unused_beep_cycles;
    assign unused_beep_cycles = ^BEEP_CYCLES;
`endif

endmodule
